// File: rtl/decode_pipe.sv
// RV32IM decode stage: decodes each accepted fetch word into an
// rv32_instr_packet_t and buffers it in a small FIFO ahead of issue.
// Illegal encodings are flagged, still buffered, and counted (saturating).

package decode_pipe_pkg;

  typedef enum logic [5:0] {
    ALU_OP_NOP    = 6'd0,
    ALU_OP_LUI    = 6'd1,
    ALU_OP_AUIPC  = 6'd2,
    ALU_OP_JAL    = 6'd3,
    ALU_OP_JALR   = 6'd4,
    ALU_OP_BEQ    = 6'd5,
    ALU_OP_BNE    = 6'd6,
    ALU_OP_BLT    = 6'd7,
    ALU_OP_BGE    = 6'd8,
    ALU_OP_BLTU   = 6'd9,
    ALU_OP_BGEU   = 6'd10,
    ALU_OP_LB     = 6'd11,
    ALU_OP_LH     = 6'd12,
    ALU_OP_LW     = 6'd13,
    ALU_OP_LBU    = 6'd14,
    ALU_OP_LHU    = 6'd15,
    ALU_OP_SB     = 6'd16,
    ALU_OP_SH     = 6'd17,
    ALU_OP_SW     = 6'd18,
    ALU_OP_ADDI   = 6'd19,
    ALU_OP_SLTI   = 6'd20,
    ALU_OP_SLTIU  = 6'd21,
    ALU_OP_XORI   = 6'd22,
    ALU_OP_ORI    = 6'd23,
    ALU_OP_ANDI   = 6'd24,
    ALU_OP_SLLI   = 6'd25,
    ALU_OP_SRLI   = 6'd26,
    ALU_OP_SRAI   = 6'd27,
    ALU_OP_ADD    = 6'd28,
    ALU_OP_SUB    = 6'd29,
    ALU_OP_SLL    = 6'd30,
    ALU_OP_SLT    = 6'd31,
    ALU_OP_SLTU   = 6'd32,
    ALU_OP_XOR    = 6'd33,
    ALU_OP_SRL    = 6'd34,
    ALU_OP_SRA    = 6'd35,
    ALU_OP_OR     = 6'd36,
    ALU_OP_AND    = 6'd37,
    ALU_OP_MUL    = 6'd38,
    ALU_OP_MULH   = 6'd39,
    ALU_OP_MULHSU = 6'd40,
    ALU_OP_MULHU  = 6'd41,
    ALU_OP_DIV    = 6'd42,
    ALU_OP_DIVU   = 6'd43,
    ALU_OP_REM    = 6'd44,
    ALU_OP_REMU   = 6'd45
  } alu_op_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm32;
    alu_op_t     alu_op;
  } rv32_instr_packet_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int ENABLE_M   = 1,
  parameter int PC_W       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output rv32_instr_packet_t out_pkt,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_count
);

  // Handshake semantics (both sides): a transfer happens on a rising edge
  // where valid && ready are both high. in_ready depends only on rst_n,
  // flush and FIFO fullness (never on out_ready), so a full FIFO refuses
  // input even while the head is being popped in the same cycle.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam rv32_instr_packet_t RESET_PKT = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm32: 32'd0, alu_op: ALU_OP_NOP
  };
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  f_rd;
  logic [4:0]  f_rs1;
  logic [4:0]  f_rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_sh;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign f_rd   = in_instr[11:7];
  assign f_rs1  = in_instr[19:15];
  assign f_rs2  = in_instr[24:20];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  assign imm_sh = {27'd0, in_instr[24:20]};

  rv32_instr_packet_t dec_pkt;
  rv32_instr_packet_t raw_pkt;
  logic               dec_illegal;

  // Decode the incoming word; illegal entries carry an all-zero NOP packet
  always_comb begin
    raw_pkt     = RESET_PKT;
    dec_illegal = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        raw_pkt.rd     = f_rd;
        raw_pkt.imm32  = imm_u;
        raw_pkt.alu_op = ALU_OP_LUI;
      end
      OPC_AUIPC: begin
        raw_pkt.rd     = f_rd;
        raw_pkt.imm32  = imm_u;
        raw_pkt.alu_op = ALU_OP_AUIPC;
      end
      OPC_JAL: begin
        raw_pkt.rd     = f_rd;
        raw_pkt.imm32  = imm_j;
        raw_pkt.alu_op = ALU_OP_JAL;
      end
      OPC_JALR: begin
        raw_pkt.rd     = f_rd;
        raw_pkt.rs1    = f_rs1;
        raw_pkt.imm32  = imm_i;
        raw_pkt.alu_op = ALU_OP_JALR;
        if (funct3 != 3'b000) dec_illegal = 1'b1;
      end
      OPC_BRANCH: begin
        raw_pkt.rs1   = f_rs1;
        raw_pkt.rs2   = f_rs2;
        raw_pkt.imm32 = imm_b;
        case (funct3)
          3'b000:  raw_pkt.alu_op = ALU_OP_BEQ;
          3'b001:  raw_pkt.alu_op = ALU_OP_BNE;
          3'b100:  raw_pkt.alu_op = ALU_OP_BLT;
          3'b101:  raw_pkt.alu_op = ALU_OP_BGE;
          3'b110:  raw_pkt.alu_op = ALU_OP_BLTU;
          3'b111:  raw_pkt.alu_op = ALU_OP_BGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        raw_pkt.rd    = f_rd;
        raw_pkt.rs1   = f_rs1;
        raw_pkt.imm32 = imm_i;
        case (funct3)
          3'b000:  raw_pkt.alu_op = ALU_OP_LB;
          3'b001:  raw_pkt.alu_op = ALU_OP_LH;
          3'b010:  raw_pkt.alu_op = ALU_OP_LW;
          3'b100:  raw_pkt.alu_op = ALU_OP_LBU;
          3'b101:  raw_pkt.alu_op = ALU_OP_LHU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        raw_pkt.rs1   = f_rs1;
        raw_pkt.rs2   = f_rs2;
        raw_pkt.imm32 = imm_s;
        case (funct3)
          3'b000:  raw_pkt.alu_op = ALU_OP_SB;
          3'b001:  raw_pkt.alu_op = ALU_OP_SH;
          3'b010:  raw_pkt.alu_op = ALU_OP_SW;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        raw_pkt.rd    = f_rd;
        raw_pkt.rs1   = f_rs1;
        raw_pkt.imm32 = imm_i;
        case (funct3)
          3'b000: raw_pkt.alu_op = ALU_OP_ADDI;
          3'b010: raw_pkt.alu_op = ALU_OP_SLTI;
          3'b011: raw_pkt.alu_op = ALU_OP_SLTIU;
          3'b100: raw_pkt.alu_op = ALU_OP_XORI;
          3'b110: raw_pkt.alu_op = ALU_OP_ORI;
          3'b111: raw_pkt.alu_op = ALU_OP_ANDI;
          3'b001: begin
            raw_pkt.imm32  = imm_sh;
            raw_pkt.alu_op = ALU_OP_SLLI;
            if (funct7 != 7'b0000000) dec_illegal = 1'b1;
          end
          default: begin
            // funct3 = 101: shift right, logical or arithmetic by funct7
            raw_pkt.imm32 = imm_sh;
            if (funct7 == 7'b0000000)      raw_pkt.alu_op = ALU_OP_SRLI;
            else if (funct7 == 7'b0100000) raw_pkt.alu_op = ALU_OP_SRAI;
            else                           dec_illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        raw_pkt.rd  = f_rd;
        raw_pkt.rs1 = f_rs1;
        raw_pkt.rs2 = f_rs2;
        if (funct7 == 7'b0000001) begin
          // M-extension group; every funct3 is a valid M op
          if (ENABLE_M == 0) dec_illegal = 1'b1;
          case (funct3)
            3'b000:  raw_pkt.alu_op = ALU_OP_MUL;
            3'b001:  raw_pkt.alu_op = ALU_OP_MULH;
            3'b010:  raw_pkt.alu_op = ALU_OP_MULHSU;
            3'b011:  raw_pkt.alu_op = ALU_OP_MULHU;
            3'b100:  raw_pkt.alu_op = ALU_OP_DIV;
            3'b101:  raw_pkt.alu_op = ALU_OP_DIVU;
            3'b110:  raw_pkt.alu_op = ALU_OP_REM;
            default: raw_pkt.alu_op = ALU_OP_REMU;
          endcase
        end else begin
          case ({funct7, funct3})
            10'b0000000_000: raw_pkt.alu_op = ALU_OP_ADD;
            10'b0100000_000: raw_pkt.alu_op = ALU_OP_SUB;
            10'b0000000_001: raw_pkt.alu_op = ALU_OP_SLL;
            10'b0000000_010: raw_pkt.alu_op = ALU_OP_SLT;
            10'b0000000_011: raw_pkt.alu_op = ALU_OP_SLTU;
            10'b0000000_100: raw_pkt.alu_op = ALU_OP_XOR;
            10'b0000000_101: raw_pkt.alu_op = ALU_OP_SRL;
            10'b0100000_101: raw_pkt.alu_op = ALU_OP_SRA;
            10'b0000000_110: raw_pkt.alu_op = ALU_OP_OR;
            10'b0000000_111: raw_pkt.alu_op = ALU_OP_AND;
            default:         dec_illegal = 1'b1;
          endcase
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Illegal encodings are passed on as a clean NOP so issue never sees junk
  always_comb begin
    dec_pkt = dec_illegal ? RESET_PKT : raw_pkt;
  end

  // FIFO state: pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  rv32_instr_packet_t pkt_mem [FIFO_DEPTH];
  logic [PC_W-1:0]    pc_mem  [FIFO_DEPTH];
  logic               ill_mem [FIFO_DEPTH];
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = rst_n && !flush && !full;
  assign out_valid = rst_n && !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointer update: reset and flush both collapse the FIFO to empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until covered by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      pkt_mem[wr_ptr[AW-1:0]] <= dec_pkt;
      pc_mem[wr_ptr[AW-1:0]]  <= in_pc;
      ill_mem[wr_ptr[AW-1:0]] <= dec_illegal;
    end
  end

  // Saturating count of illegal entries actually pushed (flush keeps it)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_count <= '0;
    end else if (push && dec_illegal && (illegal_count != CNT_MAX)) begin
      illegal_count <= illegal_count + 1'b1;
    end
  end

  // Head presentation: reset values whenever nothing valid is at the head
  always_comb begin
    out_pkt     = RESET_PKT;
    out_pc      = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_pkt     = pkt_mem[rd_ptr[AW-1:0]];
      out_pc      = pc_mem[rd_ptr[AW-1:0]];
      out_illegal = ill_mem[rd_ptr[AW-1:0]];
    end
  end

endmodule
